// File: rtl/seg_display_mux.sv
// Time-multiplexed 4-digit 7-segment driver with dead time between slots,
// blinking of the digit under edit, a blinking hour/minute colon and leading-zero blanking.
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic [3:0] hTens,
  input  logic [3:0] hOnes,
  input  logic [3:0] mTens,
  input  logic [3:0] mOnes,
  input  logic       edit_en,
  input  logic [1:0] edit_sel,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PRE_W-1:0]   pre_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [1:0]         idx;
  logic               phase;
  logic               started;
  logic [3:0]         lat_digit;

  logic               tick_c;
  logic               blink_wrap_c;
  logic [1:0]         nxt_idx_c;
  logic [3:0]         nxt_digit_c;
  logic [6:0]         nxt_seg_c;
  logic               nxt_dp_c;
  logic               blank_c;
  logic [3:0]         lit_an_c;

  // Active-low {g,f,e,d,c,b,a} pattern; non-BCD values show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Next-slot selection and per-cycle blanking of the lit anode.
  always_comb begin
    tick_c       = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
    blink_wrap_c = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    nxt_idx_c    = idx + 2'd1;
    nxt_digit_c  = hTens;
    case (nxt_idx_c)
      2'd0:    nxt_digit_c = hTens;
      2'd1:    nxt_digit_c = hOnes;
      2'd2:    nxt_digit_c = mTens;
      default: nxt_digit_c = mOnes;
    endcase
    nxt_seg_c = decode(nxt_digit_c);
    nxt_dp_c  = 1'b1;
    if (nxt_idx_c == 2'd1) begin
      nxt_dp_c = edit_en ? 1'b0 : phase;
    end
    blank_c  = (edit_en && (edit_sel == idx) && phase) ||
               (blank_lead && (idx == 2'd0) && (lat_digit == 4'd0));
    lit_an_c = blank_c ? 4'b1111 : ~(4'b0001 << idx);
  end

  // Counters, slot latching and registered display outputs.
  always_ff @(posedge clkin) begin
    if (!reset) begin
      pre_cnt   <= '0;
      blink_cnt <= '0;
      idx       <= 2'd0;
      phase     <= 1'b0;
      started   <= 1'b0;
      lat_digit <= 4'd0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      pre_cnt <= tick_c ? '0 : pre_cnt + PRE_W'(1);
      if (blink_wrap_c) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
      if (tick_c) begin
        // Slot boundary: one dead cycle while the next digit is latched.
        idx       <= nxt_idx_c;
        started   <= 1'b1;
        lat_digit <= nxt_digit_c;
        an        <= 4'b1111;
        seg       <= nxt_seg_c;
        dp        <= nxt_dp_c;
      end else if (started) begin
        an <= lit_an_c;
      end
    end
  end

endmodule
